mux_arbiter: RTL

- Two-requester arbiter and sequencer for the shared 4-bit 2:1 command mux (A path = requester A, B path = requester B, select high passes B).
- Grants ownership round-robin and drives the mux select.
- Inserts a break-before-make dead time on every ownership change.
- Preempts a long-holding owner when the other side is waiting.
- Registers the muxed command for the downstream motor/steering logic.

---
 rtl/mux_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter for the shared 4-bit 2:1
// command mux. It inserts a break-before-make dead time on every ownership
// change and preempts an owner that holds too long while the other side waits.
// The arbitrated command is registered once before it reaches the
// motor/steering logic.
// Optional build macro MUX_ARBITER_FAILSAFE_EN adds an idle watchdog. When
// nobody has owned the mux for IDLE_TIMEOUT cycles, it drives SAFE_CMD as a
// valid command.
module mux_arbiter #(
  parameter int unsigned MAX_GRANT    = 16,
  parameter int unsigned DEAD_CYCLES  = 2,
  parameter int unsigned CNT_W        = 8
`ifdef MUX_ARBITER_FAILSAFE_EN
  ,
  parameter int unsigned IDLE_TIMEOUT = 1000,
  parameter logic [3:0]  SAFE_CMD     = 4'hF
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_a_i,
  input  logic [3:0] cmd_a_i,
  input  logic       req_b_i,
  input  logic [3:0] cmd_b_i,
  output logic       grant_a_o,
  output logic       grant_b_o,
  output logic       sel_o,
  output logic [3:0] cmd_o,
  output logic       cmd_valid_o,
  output logic       failsafe_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN_A = 2'd1;
  localparam logic [1:0] S_OWN_B = 2'd2;
  localparam logic [1:0] S_DEAD  = 2'd3;

  // Last tenure cycle before a waiting requester forces a handover.
  localparam logic [CNT_W-1:0] TEN_LAST  = CNT_W'(MAX_GRANT - 1);
  // Final dead cycle, on which the next owner is chosen.
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_tenure;
  logic [CNT_W-1:0] w_tenure_nxt;
  logic [CNT_W-1:0] r_dead_cnt;
  logic [CNT_W-1:0] w_dead_nxt;
  logic             r_last_b;      // 1 = B owned last, so A wins the next tie
  logic             r_sel;
  logic [3:0]       r_cmd;
  logic             r_cmd_vld;
  logic             w_pick_a;
  logic             w_pick_b;
  logic [3:0]       w_mux_cmd;
  logic             w_fs_nxt;

  // A tie goes to whichever side did not own last.
  assign w_pick_a  = req_a_i & (~req_b_i | r_last_b);
  assign w_pick_b  = req_b_i & (~req_a_i | ~r_last_b);

  // The shared 2:1 mux itself; select high passes the B path.
  assign w_mux_cmd = r_sel ? cmd_b_i : cmd_a_i;

  // Next-state, tenure and dead-time counter decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_tenure_nxt = r_tenure;
    w_dead_nxt   = r_dead_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pick_a)      w_state_nxt = S_OWN_A;
        else if (w_pick_b) w_state_nxt = S_OWN_B;
      end
      S_OWN_A: begin
        if (!req_a_i || (req_b_i && (r_tenure >= TEN_LAST))) begin
          // A release and a preempt on the same edge both just enter DEAD.
          w_state_nxt  = S_DEAD;
          w_tenure_nxt = '0;
          w_dead_nxt   = '0;
        end else if (req_b_i) begin
          w_tenure_nxt = sat_inc(r_tenure);
        end else begin
          w_tenure_nxt = '0;
        end
      end
      S_OWN_B: begin
        if (!req_b_i || (req_a_i && (r_tenure >= TEN_LAST))) begin
          w_state_nxt  = S_DEAD;
          w_tenure_nxt = '0;
          w_dead_nxt   = '0;
        end else if (req_a_i) begin
          w_tenure_nxt = sat_inc(r_tenure);
        end else begin
          w_tenure_nxt = '0;
        end
      end
      S_DEAD: begin
        if (r_dead_cnt >= DEAD_LAST) begin
          // Requests only matter on the final dead cycle.
          w_dead_nxt = '0;
          if (w_pick_a)      w_state_nxt = S_OWN_A;
          else if (w_pick_b) w_state_nxt = S_OWN_B;
          else               w_state_nxt = S_IDLE;
        end else begin
          w_dead_nxt = sat_inc(r_dead_cnt);
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_tenure_nxt = '0;
        w_dead_nxt   = '0;
      end
    endcase
  end

  // Ownership state, counters, mux select and round-robin history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_tenure   <= '0;
      r_dead_cnt <= '0;
      r_last_b   <= 1'b1;
      r_sel      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tenure   <= w_tenure_nxt;
      r_dead_cnt <= w_dead_nxt;
      if ((w_state_nxt == S_OWN_A) && (r_state != S_OWN_A)) begin
        r_sel    <= 1'b0;
        r_last_b <= 1'b0;
      end else if ((w_state_nxt == S_OWN_B) && (r_state != S_OWN_B)) begin
        r_sel    <= 1'b1;
        r_last_b <= 1'b1;
      end
    end
  end

`ifdef MUX_ARBITER_FAILSAFE_EN
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  function automatic logic [IDLE_W-1:0] idle_inc(input logic [IDLE_W-1:0] v);
    return (v == {IDLE_W{1'b1}}) ? v : v + IDLE_W'(1);
  endfunction

  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_inc;
  logic              r_failsafe;
  logic              w_owned;
  logic              w_grant_edge;

  assign w_owned      = (r_state == S_OWN_A) || (r_state == S_OWN_B);
  assign w_grant_edge = !w_owned &&
                        ((w_state_nxt == S_OWN_A) || (w_state_nxt == S_OWN_B));
  assign w_idle_inc   = idle_inc(r_idle_cnt);
  // Failsafe latches once the idle run reaches the timeout; any grant drops it.
  assign w_fs_nxt     = w_grant_edge ? 1'b0 :
                        w_owned      ? 1'b0 :
                        (r_failsafe || (w_idle_inc >= IDLE_W'(IDLE_TIMEOUT)));

  // Idle watchdog: counts consecutive unowned cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idle_cnt <= '0;
      r_failsafe <= 1'b0;
    end else begin
      r_failsafe <= w_fs_nxt;
      if (w_grant_edge || w_owned) r_idle_cnt <= '0;
      else                         r_idle_cnt <= w_idle_inc;
    end
  end

  assign failsafe_o = r_failsafe;
`else
  assign w_fs_nxt   = 1'b0;
  assign failsafe_o = 1'b0;
`endif

  // Output command register: owner's muxed command, otherwise idle/safe value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd     <= 4'h0;
      r_cmd_vld <= 1'b0;
    end else begin
      case (r_state)
        S_OWN_A, S_OWN_B: begin
          r_cmd     <= w_mux_cmd;
          r_cmd_vld <= 1'b1;
        end
        default: begin
`ifdef MUX_ARBITER_FAILSAFE_EN
          r_cmd     <= w_fs_nxt ? SAFE_CMD : 4'h0;
          r_cmd_vld <= w_fs_nxt;
`else
          r_cmd     <= 4'h0;
          r_cmd_vld <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign grant_a_o   = (r_state == S_OWN_A);
  assign grant_b_o   = (r_state == S_OWN_B);
  assign sel_o       = r_sel;
  assign cmd_o       = r_cmd;
  assign cmd_valid_o = r_cmd_vld;

endmodule
